// File: rtl/z_update_if.sv
// z_update bus bundle: operands and learning parameters in, read strobe,
// status and updated weights out. The master drives the request side and
// the slave (z_update) drives the results.
interface z_update_if;
  logic        start;
  logic [31:0] x1, x2, x3;
  logic [31:0] w1, w2, w3;
  logic [31:0] lr;
  logic [31:0] target;
  logic [31:0] z_in;
  logic        z_read;
  logic        busy;
  logic        done;
  logic [31:0] delta;
  logic [31:0] w1_new, w2_new, w3_new;

  modport master (
    output start, x1, x2, x3, w1, w2, w3, lr, target, z_in,
    input  z_read, busy, done, delta, w1_new, w2_new, w3_new
  );

  modport slave (
    input  start, x1, x2, x3, w1, w2, w3, lr, target, z_in,
    output z_read, busy, done, delta, w1_new, w2_new, w3_new
  );
endinterface

// File: rtl/z_update.sv
// z_update: backward-pass weight update for one linear output neuron.
// delta = z - target, then w_i_new = w_i - (delta * x_i) * lr for i = 1..3,
// sharing one FP32 multiplier and one FP32 adder/subtractor across an FSM.
// Arithmetic truncates, flushes denormals to +0 and saturates overflow to
// the largest finite value of the correct sign.
module z_update (
  input  logic       clk,
  input  logic       rst,
  z_update_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPT, S_DELTA, S_MULX, S_MULL, S_SUBW, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [2:0][31:0]  x_q, w_q, wn_q;
  logic [31:0]       lr_q, tgt_q, z_q, p_q, delta_q;

  logic [31:0]       x_sel, w_sel;
  logic [31:0]       mul_a, mul_b, mul_y;
  logic [31:0]       add_a, add_b, add_y;

  // Pack sign/exponent/fraction, flushing underflow to +0 and saturating overflow.
  function automatic logic [31:0] fp_pack(input logic sign, input int e,
                                          input logic [22:0] frac);
    if (e <= 0)   return 32'd0;
    if (e >= 255) return {sign, 31'h7F7FFFFF};
    return {sign, e[7:0], frac};
  endfunction

  // Truncating FP32 multiply; any zero/denormal operand yields +0.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] prod;
    logic [22:0] frac;
    int          e;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'd0;
    prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e    = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (prod[47]) begin
      e    = e + 1;
      frac = prod[46:24];
    end else begin
      frac = prod[45:23];
    end
    return fp_pack(a[31] ^ b[31], e, frac);
  endfunction

  // Truncating FP32 add. The smaller operand is aligned with a sticky bit so
  // that truncation after a subtraction still lands on the right side.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] l, s;
    logic [7:0]  d;
    logic [49:0] ml, ms, sh;
    logic [50:0] sum;
    logic        sticky;
    int          pos, e;
    if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return 32'd0;
    if (a[30:23] == 8'd0) return b;
    if (b[30:23] == 8'd0) return a;
    if (a[30:0] >= b[30:0]) begin
      l = a;
      s = b;
    end else begin
      l = b;
      s = a;
    end
    d  = l[30:23] - s[30:23];
    ml = {1'b1, l[22:0], 26'd0};
    ms = {1'b1, s[22:0], 26'd0};
    if (d >= 8'd50) begin
      sh     = 50'd0;
      sticky = 1'b1;
    end else begin
      sh     = ms >> d;
      sticky = |(ms & ((50'd1 << d) - 50'd1));
    end
    sh[0] = sh[0] | sticky;
    if (l[31] == s[31]) sum = {1'b0, ml} + {1'b0, sh};
    else                sum = {1'b0, ml} - {1'b0, sh};
    if (sum == 51'd0) return 32'd0;
    pos = 0;
    for (int i = 0; i < 51; i++) begin
      if (sum[i]) pos = i;
    end
    e = int'(l[30:23]) + pos - 49;
    if (pos == 50) sum = sum >> 1;
    else           sum = sum << (49 - pos);
    return fp_pack(l[31], e, sum[48:26]);
  endfunction

  function automatic logic [31:0] fp_sub(input logic [31:0] a, input logic [31:0] b);
    return fp_add(a, {~b[31], b[30:0]});
  endfunction

  // Operand steering for the shared multiplier and adder.
  always_comb begin
    x_sel = (idx_q == 2'd0) ? x_q[0] : (idx_q == 2'd1) ? x_q[1] : x_q[2];
    w_sel = (idx_q == 2'd0) ? w_q[0] : (idx_q == 2'd1) ? w_q[1] : w_q[2];
    mul_a = (state_q == S_MULX) ? delta_q : p_q;
    mul_b = (state_q == S_MULX) ? x_sel   : lr_q;
    add_a = (state_q == S_DELTA) ? z_q   : w_sel;
    add_b = (state_q == S_DELTA) ? tgt_q : p_q;
    mul_y = fp_mul(mul_a, mul_b);
    add_y = fp_sub(add_a, add_b);
  end

  // Next-state logic: fixed sequence with three MULX/MULL/SUBW passes.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_READ;
          idx_d   = 2'd0;
        end
      end
      S_READ:  state_d = S_CAPT;
      S_CAPT:  state_d = S_DELTA;
      S_DELTA: state_d = S_MULX;
      S_MULX:  state_d = S_MULL;
      S_MULL:  state_d = S_SUBW;
      S_SUBW: begin
        if (idx_q == 2'd2) begin
          state_d = S_DONE;
        end else begin
          state_d = S_MULX;
          idx_d   = idx_q + 2'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Operand latches and result registers, written only in their own state.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= '0;
      w_q     <= '0;
      wn_q    <= '0;
      lr_q    <= 32'd0;
      tgt_q   <= 32'd0;
      z_q     <= 32'd0;
      p_q     <= 32'd0;
      delta_q <= 32'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            x_q   <= {bus.x3, bus.x2, bus.x1};
            w_q   <= {bus.w3, bus.w2, bus.w1};
            lr_q  <= bus.lr;
            tgt_q <= bus.target;
          end
        end
        S_CAPT:  z_q     <= bus.z_in;
        S_DELTA: delta_q <= add_y;
        S_MULX:  p_q     <= mul_y;
        S_MULL:  p_q     <= mul_y;
        S_SUBW: begin
          unique case (idx_q)
            2'd0:    wn_q[0] <= add_y;
            2'd1:    wn_q[1] <= add_y;
            default: wn_q[2] <= add_y;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign bus.z_read = (state_q == S_READ);
  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.delta  = delta_q;
  assign bus.w1_new = wn_q[0];
  assign bus.w2_new = wn_q[1];
  assign bus.w3_new = wn_q[2];

endmodule

// File: tb/tb_z_update.sv
// Bench for z_update: directed vectors, a cycle-level behavioural model that
// computes FP32 results through real arithmetic with explicit truncation,
// and a per-cycle comparison of every output against that model.
module tb_z_update;
  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nerr = 0;
  int   nzr  = 0;
  int   ndn  = 0;
  logic chk_en = 1'b0;

  z_update_if bus ();

  z_update dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] z, t, lr, x1, x2, x3, w1, w2, w3;
  } vec_t;

  // ---------------- model ----------------
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    if (e >= 255) return {d[63], 31'h7F7FFFFF};
    if (e <= 0) return 32'd0;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] m_mul(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) * f2r(b));
  endfunction

  function automatic logic [31:0] m_sub(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) - f2r(b));
  endfunction

  int          ph = 0;
  logic [31:0] mx[3], mw[3], mwn[3];
  logic [31:0] mlr, mt, mz, md;

  // Cycle position within an operation decides what the outputs must show.
  always @(posedge clk) begin
    if (rst) begin
      ph = 0;
      md = 32'd0;
      for (int i = 0; i < 3; i++) mwn[i] = 32'd0;
    end else if (ph == 0) begin
      if (bus.start) begin
        mx[0] = bus.x1; mx[1] = bus.x2; mx[2] = bus.x3;
        mw[0] = bus.w1; mw[1] = bus.w2; mw[2] = bus.w3;
        mlr = bus.lr;
        mt  = bus.target;
        ph  = 1;
      end
    end else begin
      if (ph == 2) mz = bus.z_in;
      if (ph == 3) md = m_sub(mz, mt);
      if (ph == 6 || ph == 9 || ph == 12)
        mwn[(ph - 6) / 3] = m_sub(mw[(ph - 6) / 3],
                                  m_mul(m_mul(md, mx[(ph - 6) / 3]), mlr));
      ph = (ph == 13) ? 0 : ph + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model each cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",   32'(bus.busy),   32'(ph != 0));
      chk("z_read", 32'(bus.z_read), 32'(ph == 1));
      chk("done",   32'(bus.done),   32'(ph == 13));
      chk("delta",  bus.delta,  md);
      chk("w1_new", bus.w1_new, mwn[0]);
      chk("w2_new", bus.w2_new, mwn[1]);
      chk("w3_new", bus.w3_new, mwn[2]);
      if (bus.z_read === 1'b1) nzr++;
      if (bus.done === 1'b1) ndn++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic junk_data();
    bus.x1 = $urandom; bus.x2 = $urandom; bus.x3 = $urandom;
    bus.w1 = $urandom; bus.w2 = $urandom; bus.w3 = $urandom;
    bus.lr = $urandom; bus.target = $urandom;
  endtask

  task automatic set_vec(input vec_t v);
    bus.x1 = v.x1; bus.x2 = v.x2; bus.x3 = v.x3;
    bus.w1 = v.w1; bus.w2 = v.w2; bus.w3 = v.w3;
    bus.lr = v.lr; bus.target = v.t;
  endtask

  // Called at a negedge while idle; z_in carries the real value only in cycle 2.
  task automatic run_op(input vec_t v, input int sa, input int sb, input int rst_at);
    nzr = 0;
    ndn = 0;
    set_vec(v);
    bus.z_in  = $urandom;
    bus.start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 14; c++) begin
      junk_data();
      bus.z_in  = (c == 2) ? v.z : $urandom;
      bus.start = (c == sa || c == sb);
      rst       = (c == rst_at);
      @(negedge clk);
    end
    bus.start = 1'b0;
    rst       = 1'b0;
  endtask

  vec_t vb, vz, vs, vt, vm;

  initial begin
    vb = '{z:32'h3FC00000, t:32'h3F800000, lr:32'h3F000000,
           x1:32'h3F800000, x2:32'h40000000, x3:32'h00000000,
           w1:32'h3F800000, w2:32'h00000000, w3:32'h40400000};
    vz = '{z:32'h40A00000, t:32'h40A00000, lr:32'h3DCCCCCD,
           x1:32'h3F99999A, x2:32'hC1200000, x3:32'h40490FDB,
           w1:32'h3E99999A, w2:32'hBF400000, w3:32'h42C80000};
    vs = '{z:32'h7F000000, t:32'h00000000, lr:32'h3F800000,
           x1:32'h40000000, x2:32'h00000000, x3:32'h00000000,
           w1:32'h00000000, w2:32'h3F800000, w3:32'h00000000};
    vt = '{z:32'h3F800000, t:32'h33000000, lr:32'h3F800000,
           x1:32'h3F800000, x2:32'h40000000, x3:32'h33000000,
           w1:32'h3F800000, w2:32'h00000000, w3:32'h3F800000};
    vm = '{z:32'h40490FDB, t:32'h3DCCCCCD, lr:32'h3C23D70A,
           x1:32'hC0000000, x2:32'h3F8CCCCD, x3:32'h41200000,
           w1:32'h3E800000, w2:32'hBF19999A, w3:32'h3A83126F};

    // Reset with start also high and random inputs: reset must win.
    rst = 1'b1;
    bus.start = 1'b1;
    bus.z_in  = $urandom;
    junk_data();
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_delta", bus.delta, 32'd0);
    chk("rst_w3",    bus.w3_new, 32'd0);
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);

    // Pin the model to hand-worked values.
    chk("mdl_mul",  m_mul(32'h3F000000, 32'h40000000), 32'h3F800000);
    chk("mdl_sat",  m_mul(32'h7F000000, 32'h40000000), 32'h7F7FFFFF);
    chk("mdl_sub",  m_sub(32'h3F800000, 32'h3E800000), 32'h3F400000);
    chk("mdl_rtz",  m_sub(32'h3F800000, 32'h33000000), 32'h3F7FFFFF);

    // Basic update.
    run_op(vb, 0, 0, 0);
    chk("basic_delta", bus.delta,  32'h3F000000);
    chk("basic_w1",    bus.w1_new, 32'h3F400000);
    chk("basic_w2",    bus.w2_new, 32'hBF000000);
    chk("basic_w3",    bus.w3_new, 32'h40400000);
    chk("basic_nzr",   32'(nzr), 32'd1);
    chk("basic_ndn",   32'(ndn), 32'd1);

    // Zero error: weights pass through unchanged.
    run_op(vz, 0, 0, 0);
    chk("zero_delta", bus.delta,  32'h00000000);
    chk("zero_w1",    bus.w1_new, 32'h3E99999A);
    chk("zero_w2",    bus.w2_new, 32'hBF400000);
    chk("zero_w3",    bus.w3_new, 32'h42C80000);

    // Start pulses while busy are ignored.
    run_op(vb, 3, 8, 0);
    chk("busy_w2",  bus.w2_new, 32'hBF000000);
    chk("busy_nzr", 32'(nzr), 32'd1);
    chk("busy_ndn", 32'(ndn), 32'd1);

    // Reset in cycle 6 aborts; next operation is normal.
    run_op(vt, 0, 0, 6);
    chk("abort_delta", bus.delta,  32'd0);
    chk("abort_w1",    bus.w1_new, 32'd0);
    chk("abort_ndn",   32'(ndn), 32'd0);
    run_op(vt, 0, 0, 0);
    chk("rtz_delta", bus.delta,  32'h3F7FFFFF);
    chk("rtz_w1",    bus.w1_new, 32'h33800000);
    chk("rtz_w2",    bus.w2_new, 32'hBFFFFFFF);
    chk("rtz_w3",    bus.w3_new, 32'h3F7FFFFF);
    chk("rtz_ndn",   32'(ndn), 32'd1);

    // Overflow saturation.
    run_op(vs, 0, 0, 0);
    chk("sat_delta", bus.delta,  32'h7F000000);
    chk("sat_w1",    bus.w1_new, 32'hFF7FFFFF);
    chk("sat_w2",    bus.w2_new, 32'h3F800000);
    chk("sat_w3",    bus.w3_new, 32'h00000000);

    // Mixed values, model only.
    run_op(vm, 0, 0, 0);

    // start held high: a new operation every 14 cycles.
    nzr = 0;
    ndn = 0;
    set_vec(vm);
    bus.z_in  = vm.z;
    bus.start = 1'b1;
    repeat (28) @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("b2b_nzr", 32'(nzr), 32'd2);
    chk("b2b_ndn", 32'(ndn), 32'd2);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
